uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 67 ++++++
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity sense, vote helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // 2-of-3 vote across the three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority voter.
// Latency: 2 clocks line-to-rx_s; bit decision available at edge_cnt = N/2+2.
// Backpressure: none; the serial line cannot be stalled.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int N = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_line,
    input  logic cnt_en,
    output logic rx_s,
    output logic bit_val,
    output logic bit_vld,
    output logic bit_end
);

    localparam int EW = $clog2(N);
    localparam logic [EW-1:0] SMP0 = EW'(N/2 - 1);
    localparam logic [EW-1:0] SMP1 = EW'(N/2);
    localparam logic [EW-1:0] SMP2 = EW'(N/2 + 1);
    localparam logic [EW-1:0] DECIDE = EW'(N/2 + 2);
    localparam logic [EW-1:0] LAST = EW'(N - 1);

    logic          rx_m;
    logic [EW-1:0] edge_cnt;
    logic [2:0]    smp;

    // two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_line;
            rx_s <= rx_m;
        end
    end

    // position within the current bit; held at 0 while the receiver is idle
    always_ff @(posedge clk) begin
        if (rst || !cnt_en) begin
            edge_cnt <= '0;
        end else if (edge_cnt == LAST) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // capture three consecutive samples around the middle of the bit
    always_ff @(posedge clk) begin
        if (rst) begin
            smp <= 3'b000;
        end else if (cnt_en) begin
            if (edge_cnt == SMP0) smp[0] <= rx_s;
            if (edge_cnt == SMP1) smp[1] <= rx_s;
            if (edge_cnt == SMP2) smp[2] <= rx_s;
        end
    end

    assign bit_val = maj3(smp[0], smp[1], smp[2]);
    assign bit_vld = cnt_en && (edge_cnt == DECIDE);
    assign bit_end = cnt_en && (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB-first, optional parity, one stop bit.
// Latency: DATA_VALID registered, about N/2+4 clocks after the stop bit begins on the line.
// Backpressure: none; DATA_VALID is a single-cycle pulse the consumer must take.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,   // at least 2
    parameter int N          = 16,  // even, at least 8
    parameter int PAR_EN     = 0,
    parameter int PAR_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    output logic                  DATA_VALID,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic [DATA_WIDTH-1:0] P_DATA_OUT
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic PAR_SENSE = (PAR_TYPE != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_e             state, state_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_s;
    logic                  bit_val;
    logic                  bit_vld;
    logic                  bit_end;
    logic                  exp_par;

    uart_rx_sampler #(.N(N)) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx_line (RX_IN),
        .cnt_en  (state != IDLE),
        .rx_s    (rx_s),
        .bit_val (bit_val),
        .bit_vld (bit_vld),
        .bit_end (bit_end)
    );

    assign exp_par = (^shreg) ^ PAR_SENSE;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; STOP leaves at the decision point so a back-to-back start is not missed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!rx_s) state_nxt = START;
            START: begin
                if (bit_vld && bit_val) state_nxt = IDLE;
                else if (bit_end)       state_nxt = DATA;
            end
            DATA:   if (bit_end && (bit_cnt == LAST_BIT))
                        state_nxt = (PAR_EN != 0) ? PARITY : STOP;
            PARITY: if (bit_end) state_nxt = STOP;
            STOP:   if (bit_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // deserializer, frame checks and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            P_DATA_OUT   <= '0;
            DATA_VALID   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (state == IDLE || state == START) begin
                bit_cnt <= '0;
            end
            // a confirmed start bit opens a new frame, so stale errors go away
            if (state == START && bit_vld && !bit_val) begin
                parity_error <= 1'b0;
                stop_error   <= 1'b0;
            end
            if (state == DATA && bit_vld) begin
                shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            end
            if (state == DATA && bit_end) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            if (state == PARITY && bit_vld && (bit_val != exp_par)) begin
                parity_error <= 1'b1;
            end
            if (state == STOP && bit_vld) begin
                stop_error <= !bit_val;
                if (bit_val && !parity_error) begin
                    P_DATA_OUT <= shreg;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int      N    = 16;
    localparam int      W    = 8;
    localparam realtime TBIT = 160.0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rx  = 2'b11;
    logic [1:0] dv;
    logic [1:0] pe;
    logic [1:0] se;
    logic [7:0] pd [2];

    int checks = 0;
    int fails  = 0;

    // reference model: expected words per receiver and the flag/data levels a frame leaves behind
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] m_data [2];
    logic       m_pe [2];
    logic       m_se [2];
    int         par_en [2];

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(W), .N(N), .PAR_EN(0), .PAR_TYPE(0)) dut0 (
        .clk(clk), .rst(rst), .RX_IN(rx[0]), .DATA_VALID(dv[0]),
        .parity_error(pe[0]), .stop_error(se[0]), .P_DATA_OUT(pd[0])
    );

    uart_rx #(.DATA_WIDTH(W), .N(N), .PAR_EN(1), .PAR_TYPE(0)) dut1 (
        .clk(clk), .rst(rst), .RX_IN(rx[1]), .DATA_VALID(dv[1]),
        .parity_error(pe[1]), .stop_error(se[1]), .P_DATA_OUT(pd[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int s, input logic [7:0] act);
        logic [7:0] e;
        logic       empty;
        empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checks++;
            fails++;
            $display("FAIL pulse%0d_unexpected: got word 0x%0h, expected no pulse", s, act);
        end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("data%0d", s), act, e);
        end
    endtask

    // monitor: every DATA_VALID pulse must match the oldest good frame sent to that receiver
    always @(negedge clk) begin
        if (dv[0]) pop_cmp(0, pd[0]);
        if (dv[1]) pop_cmp(1, pd[1]);
    end

    task automatic check_levels(input int s, input string tag);
        chk($sformatf("%s_perr%0d", tag, s), pe[s], m_pe[s]);
        chk($sformatf("%s_serr%0d", tag, s), se[s], m_se[s]);
        chk($sformatf("%s_pdata%0d", tag, s), pd[s], m_data[s]);
    endtask

    // one frame on line s; gap = idle clocks afterwards (0 = next start follows immediately)
    task automatic send_frame(input int s, input logic [7:0] d, input logic pb, input logic sb,
                              input realtime bt, input int gap);
        logic par_ok;
        par_ok  = (par_en[s] == 0) || (pb == ^d);
        m_pe[s] = !par_ok;
        m_se[s] = !sb;
        if (par_ok && sb) begin
            m_data[s] = d;
            if (s == 0) q0.push_back(d);
            else        q1.push_back(d);
        end
        rx[s] = 1'b0;
        #(bt);
        for (int i = 0; i < W; i++) begin
            rx[s] = d[i];
            #(bt);
        end
        if (par_en[s] != 0) begin
            rx[s] = pb;
            #(bt);
        end
        rx[s] = sb;
        #(bt);
        rx[s] = 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
            check_levels(s, "frame");
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        logic       sb;
        int         s;
        int         err;
        int         gap;
        int         jit;
        realtime    bt;

        par_en[0] = 0;
        par_en[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 8'h00;
            m_pe[i]   = 1'b0;
            m_se[i]   = 1'b0;
        end

        // reset state
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_dv%0d", i), dv[i], 1'b0);
            check_levels(i, "rst");
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // plain frame, default parameters
        send_frame(0, 8'hB3, 1'b0, 1'b1, TBIT, 20);
        // even parity: correct parity bit, then wrong parity bit
        send_frame(1, 8'hB3, 1'b1, 1'b1, TBIT, 20);
        send_frame(1, 8'hB3, 1'b0, 1'b1, TBIT, 20);
        // stop bit low, then a good frame clears the flag
        send_frame(0, 8'h5A, 1'b0, 1'b0, TBIT, 2 * N + 8);
        send_frame(0, 8'h3C, 1'b0, 1'b1, TBIT, 20);
        // parity flag also clears on the next good frame
        send_frame(1, 8'h3C, 1'b0, 1'b1, TBIT, 20);

        // short low glitch must not start a frame or touch any flag
        rx[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (3 * N) @(posedge clk);
        #1;
        check_levels(0, "glitch");

        // back-to-back frames with no idle between stop and next start
        send_frame(0, 8'h55, 1'b0, 1'b1, TBIT, 0);
        send_frame(0, 8'hA3, 1'b0, 1'b1, TBIT, 20);

        // reset during data bit 3 aborts the frame and clears everything
        send_frame(1, 8'h12, 1'b1, 1'b1, TBIT, 20);
        d = 8'h81;
        rx[1] = 1'b0;
        #(TBIT);
        for (int i = 0; i < 3; i++) begin
            rx[1] = d[i];
            #(TBIT);
        end
        rx[1] = d[3];
        #(TBIT / 2);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        rx[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 8'h00;
            m_pe[i]   = 1'b0;
            m_se[i]   = 1'b0;
            chk($sformatf("midrst_dv%0d", i), dv[i], 1'b0);
            check_levels(i, "midrst");
        end
        rst = 1'b0;
        repeat (2 * N) @(posedge clk);
        #1;
        send_frame(1, 8'h81, 1'b0, 1'b1, TBIT, 20);

        // randomized frames: random data, occasional parity/stop faults, small baud error
        for (int n = 0; n < 60; n++) begin
            s   = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            err = int'($urandom_range(0, 7));
            pb  = (^d) ^ (err == 1);
            sb  = (err != 2);
            if (sb) begin
                jit = int'($urandom_range(0, 40)) - 20;
                bt  = TBIT + jit / 10.0;
                gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(4, 40));
            end else begin
                bt  = TBIT;
                gap = 2 * N + 8;
            end
            send_frame(s, d, pb, sb, bt, gap);
        end

        repeat (4 * N) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_levels(i, "final");
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
